// File: rtl/add_seq_pkg.sv
// add_seq_pkg
//   Shared types and helpers for the nibble-serial adder sequencer.
//   - state_t   : sequencer FSM states (IDLE, RUN, DONE)
//   - NIB_W     : width of the time-shared adder slice in bits
//   - idx_width : bit width needed to index all nibbles, never below 1
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // A single-nibble operand still needs a one-bit index register, so
  // clamp the clog2 result to a minimum of 1.
  function automatic int idx_width(input int nib);
    if (nib <= 1) begin
      return 1;
    end
    return $clog2(nib);
  endfunction

endpackage

// File: rtl/add4_slice.sv
// add4_slice
//   Purely combinational 4-bit ripple-carry adder built from per-bit
//   full adders. This is the one slice shared by every nibble of the
//   wide addition.
//   Ports:
//     a4, b4 : 4-bit operand nibbles
//     ci     : carry into bit 0
//     s4     : 4-bit sum nibble
//     co     : carry out of bit 3
module add4_slice (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  // One full adder per bit; the carry ripples from bit 0 up to bit 3.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s4[i]   = a4[i] ^ b4[i] ^ c[i];
    assign c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/add_nibble_seq.sv
// add_nibble_seq
//   Multi-cycle wide adder. Operands are accepted over a valid/ready
//   handshake, then added one nibble per clock (LSB first) through a
//   single add4_slice, with the carry chained through a register. The
//   result is offered over a valid/ready handshake.
//
//   Optional build macro ADD_NIBBLE_SEQ_OVF_EN adds a two's-complement
//   overflow output registered together with the final nibble.
//
//   Ports:
//     clk        : rising-edge clock
//     rst        : asynchronous active-high reset
//     in_valid   : operand request valid
//     in_ready   : high while idle (combinational from state)
//     a, b, cin  : operands, sampled only on accept
//     out_valid  : result valid
//     out_ready  : consumer accepts result
//     sum        : registered WIDTH-bit sum
//     carry      : registered carry-out of the MSB nibble
//     busy       : high whenever the sequencer is not idle
//     overflow   : (ADD_NIBBLE_SEQ_OVF_EN only) signed overflow flag
module add_nibble_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
`ifdef ADD_NIBBLE_SEQ_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_width(NIB);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic             creg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       a4;
  logic [3:0]       b4;
  logic [3:0]       s4;
  logic             co;
  logic             last_nib;

  assign last_nib = (idx == IW'(NIB - 1));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Steer the nibble selected by idx from the captured operands into the
  // shared slice. An explicit compare loop keeps index arithmetic out of
  // the part-select.
  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        a4 = a_reg[NIB_W*i +: NIB_W];
        b4 = b_reg[NIB_W*i +: NIB_W];
      end
    end
  end

  add4_slice u_slice (
    .a4 (a4),
    .b4 (b4),
    .ci (creg),
    .s4 (s4),
    .co (co)
  );

  // State register; reset returns to IDLE immediately, discarding any
  // operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. RUN lasts exactly NIB cycles with no early exit, so
  // a carry can always ripple the whole width. DONE waits for the result
  // handshake, which is only possible once out_valid has been raised.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. On accept the operands are captured and the sum
  // cleared; each RUN cycle writes one sum nibble and chains the carry.
  // out_valid is registered from the DONE state, so it rises on the edge
  // after the final nibble is written and falls on the edge that
  // completes the result handshake. sum and carry are left untouched in
  // IDLE so the last result stays readable until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      creg      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            creg  <= cin;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
              sum[NIB_W*i +: NIB_W] <= s4;
            end
          end
          creg <= co;
          if (last_nib) begin
            idx   <= '0;
            carry <= co;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
            overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (s4[NIB_W-1] != a_reg[WIDTH-1]);
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
